// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: FSM states, error codes and
// the byte-level constants used to build and recognise instruction words.
package instruction_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_OVERFLOW = 2'b10
  } loader_err_t;

  localparam int BYTE_SIZE = 8;
  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  // The HALT instruction is every byte of the word set to this value.
  localparam logic [BYTE_SIZE-1:0] HALT_BYTE = 8'hFF;

endpackage

// File: rtl/instruction_loader_timeout_counter.sv
// Clearable up-counter that stops at LIMIT-1 and flags that terminal count,
// used to detect a stalled byte stream in the middle of a word.
module loader_timeout_counter #(
  parameter int LIMIT = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] TERMINAL = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_enable && (count != TERMINAL)) begin
      count <= count + CW'(1);
    end
  end

  assign o_terminal = (count == TERMINAL);

endmodule

// File: rtl/instruction_loader.sv
// Packs UART bytes big-endian into instruction words and writes them to the
// instruction memory, stopping on HALT, memory overflow or a mid-word stall.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 64,
  parameter int TIMEOUT_CYCLES     = 1_000_000
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic                                     i_start,
  input  logic [BYTE_SIZE-1:0]                     i_rx_data,
  input  logic                                     i_rx_valid,
  input  logic                                     i_mem_full,
  output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0]  o_instruction,
  output logic                                     o_instr_write,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic                                     o_error,
  output logic [1:0]                               o_err_code,
  output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0]   o_words_loaded
);

  localparam int WORD_W = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam int PACK_W = WORD_W - BYTE_SIZE;
  localparam int IDX_W  = $clog2(WORD_SIZE_IN_BYTES + 1);
  localparam int CNT_W  = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_SIZE_IN_BYTES - 1);
  localparam logic [CNT_W-1:0]  MEM_LIMIT = CNT_W'(MEM_SIZE_IN_WORDS);
  localparam logic [WORD_W-1:0] INSTRUCTION_HALT = {WORD_SIZE_IN_BYTES{HALT_BYTE}};

  loader_state_t    state;
  logic [IDX_W-1:0] byte_idx;
  logic [PACK_W-1:0] pack_reg;
  logic             timer_enable;
  logic             timer_expired;

  // The stall timer only runs while a word is partially packed and no byte arrives.
  assign timer_enable = (state == ST_COLLECT) && (byte_idx != '0) && !i_rx_valid;

  loader_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (!timer_enable),
    .i_enable  (timer_enable),
    .o_terminal(timer_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state          <= ST_IDLE;
      byte_idx       <= '0;
      pack_reg       <= '0;
      o_instruction  <= '0;
      o_instr_write  <= LOW;
      o_busy         <= LOW;
      o_done         <= LOW;
      o_error        <= LOW;
      o_err_code     <= ERR_NONE;
      o_words_loaded <= '0;
    end else begin
      o_instr_write <= LOW;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            state          <= ST_COLLECT;
            byte_idx       <= '0;
            o_words_loaded <= '0;
            o_err_code     <= ERR_NONE;
            o_busy         <= HIGH;
            o_done         <= LOW;
            o_error        <= LOW;
          end
        end
        ST_COLLECT: begin
          if (i_rx_valid) begin
            if (byte_idx == LAST_IDX) begin
              o_instruction <= {pack_reg, i_rx_data};
              byte_idx      <= '0;
              state         <= ST_WRITE;
            end else begin
              pack_reg <= PACK_W'({pack_reg, i_rx_data});
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end else if (timer_expired && (byte_idx != '0)) begin
            state      <= ST_ERROR;
            o_err_code <= ERR_TIMEOUT;
            o_busy     <= LOW;
            o_error    <= HIGH;
          end
        end
        ST_WRITE: begin
          // A byte arriving here already belongs to the next word.
          if (i_rx_valid) begin
            pack_reg <= PACK_W'({pack_reg, i_rx_data});
            byte_idx <= byte_idx + IDX_W'(1);
          end
          if (i_mem_full || (o_words_loaded == MEM_LIMIT)) begin
            state      <= ST_ERROR;
            o_err_code <= ERR_OVERFLOW;
            o_busy     <= LOW;
            o_error    <= HIGH;
          end else begin
            o_instr_write  <= HIGH;
            o_words_loaded <= o_words_loaded + CNT_W'(1);
            if (o_instruction == INSTRUCTION_HALT) begin
              state  <= ST_DONE;
              o_busy <= LOW;
              o_done <= HIGH;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (i_rx_valid) begin
            pack_reg <= PACK_W'({pack_reg, i_rx_data});
            byte_idx <= byte_idx + IDX_W'(1);
          end
          state <= ST_COLLECT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomised bench for instruction_loader: a word-level model predicts the
// strobed words and the final flags of each load session.
module tb_instruction_loader;

  localparam int W   = 4;
  localparam int MEM = 4;
  localparam int TMO = 100;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_mem_full = 1'b0;
  logic [31:0] o_instruction;
  logic        o_instr_write;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [1:0]  o_err_code;
  logic [2:0]  o_words_loaded;

  int checks = 0;
  int errors = 0;
  logic [31:0] strobes[$];
  logic [31:0] sess_words[$];
  int   strobe_runs = 0;
  logic prev_write = 1'b0;

  instruction_loader #(
    .WORD_SIZE_IN_BYTES(W),
    .MEM_SIZE_IN_WORDS (MEM),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_rx_data     (i_rx_data),
    .i_rx_valid    (i_rx_valid),
    .i_mem_full    (i_mem_full),
    .o_instruction (o_instruction),
    .o_instr_write (o_instr_write),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_err_code    (o_err_code),
    .o_words_loaded(o_words_loaded)
  );

  always #5 i_clk = ~i_clk;

  // Record every strobed word and any strobe that lasts longer than one cycle.
  always @(negedge i_clk) begin
    if (o_instr_write) strobes.push_back(o_instruction);
    if (o_instr_write && prev_write) strobe_runs++;
    prev_write = o_instr_write;
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input int gap);
    @(negedge i_clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    repeat (gap) @(negedge i_clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < W; i++) apply_stimulus(w[31-8*i -: 8], $urandom_range(7, 1));
  endtask

  task automatic pulse_start();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    int n = 0;
    while (!(o_done || o_error) && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    check_output({tag, "_finished"}, 64'(o_done || o_error), 64'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_instr"}, 64'(o_instruction), 64'(0));
    check_output({tag, "_write"}, 64'(o_instr_write), 64'(0));
    check_output({tag, "_busy"},  64'(o_busy), 64'(0));
    check_output({tag, "_done"},  64'(o_done), 64'(0));
    check_output({tag, "_error"}, 64'(o_error), 64'(0));
    check_output({tag, "_code"},  64'(o_err_code), 64'(0));
    check_output({tag, "_count"}, 64'(o_words_loaded), 64'(0));
  endtask

  // Word-level model: words are written in order until HALT is written or
  // the memory is full, in which case the next word is an overflow.
  task automatic run_session(input string tag);
    logic [31:0] exp_q[$];
    logic        exp_done = 1'b0;
    logic [1:0]  exp_code = 2'b00;
    foreach (sess_words[i]) begin
      if (exp_q.size() == MEM) begin
        exp_code = 2'b10;
        break;
      end
      exp_q.push_back(sess_words[i]);
      if (sess_words[i] == HALT) begin
        exp_done = 1'b1;
        break;
      end
    end
    strobes.delete();
    pulse_start();
    foreach (sess_words[i]) send_word(sess_words[i]);
    wait_finish(tag);
    repeat (3) @(negedge i_clk);
    check_output({tag, "_strobes"}, 64'(strobes.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      check_output($sformatf("%s_word%0d", tag, i),
                   (i < strobes.size()) ? 64'(strobes[i]) : {64{1'bx}}, 64'(exp_q[i]));
    check_output({tag, "_done"},  64'(o_done), 64'(exp_done));
    check_output({tag, "_error"}, 64'(o_error), 64'(exp_code != 2'b00));
    check_output({tag, "_code"},  64'(o_err_code), 64'(exp_code));
    check_output({tag, "_count"}, 64'(o_words_loaded), 64'(exp_q.size()));
    check_output({tag, "_busy"},  64'(o_busy), 64'(0));
  endtask

  function automatic logic [31:0] random_word();
    logic [31:0] w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  initial begin
    logic [31:0] fresh;
    int n;

    // Reset state
    #1 i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    check_idle_outputs("reset");
    @(negedge i_clk);
    i_reset = 1'b1;

    // Directed load ending in HALT
    sess_words = '{32'h2010_0004, HALT};
    run_session("t1");

    // Stall mid-word: three bytes then silence
    strobes.delete();
    pulse_start();
    apply_stimulus(8'h11, 2);
    apply_stimulus(8'h22, 2);
    apply_stimulus(8'h33, 0);
    repeat (TMO - 5) @(negedge i_clk);
    check_output("t2_early_error", 64'(o_error), 64'(0));
    check_output("t2_early_busy",  64'(o_busy), 64'(1));
    repeat (10) @(negedge i_clk);
    check_output("t2_error",   64'(o_error), 64'(1));
    check_output("t2_code",    64'(o_err_code), 64'(1));
    check_output("t2_strobes", 64'(strobes.size()), 64'(0));

    // More words than the memory holds
    sess_words.delete();
    for (int i = 0; i < 5; i++) sess_words.push_back(random_word());
    run_session("t3");

    // Memory reports full on the first word
    strobes.delete();
    i_mem_full = 1'b1;
    pulse_start();
    send_word(32'h1234_5678);
    repeat (4) @(negedge i_clk);
    check_output("t4_strobes", 64'(strobes.size()), 64'(0));
    check_output("t4_error",   64'(o_error), 64'(1));
    check_output("t4_code",    64'(o_err_code), 64'(2));
    check_output("t4_count",   64'(o_words_loaded), 64'(0));
    i_mem_full = 1'b0;

    // Asynchronous reset in the middle of a word
    pulse_start();
    apply_stimulus(8'hAB, 2);
    apply_stimulus(8'hCD, 2);
    @(negedge i_clk);
    #2 i_reset = 1'b0;
    #1 check_idle_outputs("t5_reset");
    @(negedge i_clk);
    i_reset = 1'b1;
    fresh = random_word();
    sess_words = '{fresh, HALT};
    run_session("t5");

    // Re-arm after DONE; a start pulse mid-word must be ignored
    strobes.delete();
    pulse_start();
    apply_stimulus(8'hFF, 2);
    apply_stimulus(8'hFF, 2);
    pulse_start();
    apply_stimulus(8'hFF, 2);
    apply_stimulus(8'hFF, 2);
    wait_finish("t6");
    repeat (3) @(negedge i_clk);
    check_output("t6_strobes", 64'(strobes.size()), 64'(1));
    check_output("t6_word", (strobes.size() > 0) ? 64'(strobes[0]) : {64{1'bx}}, 64'(HALT));
    check_output("t6_done",  64'(o_done), 64'(1));
    check_output("t6_count", 64'(o_words_loaded), 64'(1));

    // Random sessions of 0..5 words followed by HALT
    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(5, 0);
      sess_words.delete();
      for (int i = 0; i < n; i++) sess_words.push_back(random_word());
      sess_words.push_back(HALT);
      run_session($sformatf("rnd%0d", s));
    end

    check_output("strobe_width", 64'(strobe_runs), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
